// File: rtl/rx_sequencer.sv
// Receive-chain sequencer: walks a packet through short-preamble search,
// long-preamble search and decode, then flushes all stages for a fixed
// number of clocks before re-arming on a fresh power-detect rising edge.
module rx_sequencer #(
  parameter int SR_SHORT_TO  = 10,
  parameter int SR_LONG_TO   = 11,
  parameter int FLUSH_CYCLES = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [31:0] set_data,
  input  logic        sample_in_strobe,
  input  logic        power_trigger,
  input  logic        short_detected,
  input  logic        long_detected,
  input  logic        pkt_done,
  input  logic        pkt_fail,
  output logic        sync_short_enable,
  output logic        sync_long_enable,
  output logic        decode_enable,
  output logic        stage_reset,
  output logic [2:0]  state,
  output logic [15:0] pkt_count,
  output logic [15:0] abort_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SHORT  = 3'd1,
    S_LONG   = 3'd2,
    S_DECODE = 3'd3,
    S_FLUSH  = 3'd4
  } state_t;

  localparam int FLUSH_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(FLUSH_CYCLES - 1);

  state_t              state_reg;
  logic                trig_d_reg;
  logic [15:0]         wait_cnt_reg;
  logic [15:0]         short_to_reg;
  logic [15:0]         long_to_reg;
  logic [FLUSH_W-1:0]  flush_cnt_reg;

  logic        tick;
  logic        trig_rise;
  logic [15:0] abort_count_sat;
  logic [15:0] pkt_count_sat;
  logic        unused_set_data;

  // Only the low half of the settings word carries a timeout value.
  assign unused_set_data = ^set_data[31:16];

  // A sample tick only counts while the block is enabled.
  assign tick      = enable & sample_in_strobe;
  assign trig_rise = power_trigger & ~trig_d_reg;

  // Statistics counters stick at all-ones instead of wrapping.
  assign abort_count_sat = (abort_count == 16'hFFFF) ? abort_count : abort_count + 16'd1;
  assign pkt_count_sat   = (pkt_count == 16'hFFFF) ? pkt_count : pkt_count + 16'd1;

  assign state = state_reg;

  // Settings bus: timeout registers take the new value one clock after the strobe.
  always_ff @(posedge clock) begin
    if (reset) begin
      short_to_reg <= 16'd320;
      long_to_reg  <= 16'd640;
    end else if (set_stb) begin
      if (set_addr == 8'(SR_SHORT_TO)) short_to_reg <= set_data[15:0];
      if (set_addr == 8'(SR_LONG_TO))  long_to_reg  <= set_data[15:0];
    end
  end

  // Packet sequencing FSM; every output is driven straight from this register block.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg         <= S_IDLE;
      trig_d_reg        <= 1'b0;
      wait_cnt_reg      <= 16'd0;
      flush_cnt_reg     <= '0;
      sync_short_enable <= 1'b0;
      sync_long_enable  <= 1'b0;
      decode_enable     <= 1'b0;
      stage_reset       <= 1'b0;
      pkt_count         <= 16'd0;
      abort_count       <= 16'd0;
    end else begin
      if (tick) trig_d_reg <= power_trigger;

      case (state_reg)
        S_IDLE: begin
          if (tick && trig_rise) begin
            state_reg         <= S_SHORT;
            wait_cnt_reg      <= 16'd0;
            sync_short_enable <= 1'b1;
          end
        end

        S_SHORT: begin
          if (!enable) begin
            state_reg         <= S_FLUSH;
            sync_short_enable <= 1'b0;
            sync_long_enable  <= 1'b0;
            decode_enable     <= 1'b0;
            stage_reset       <= 1'b1;
            flush_cnt_reg     <= '0;
          end else if (tick) begin
            if (short_detected) begin
              state_reg         <= S_LONG;
              sync_short_enable <= 1'b0;
              sync_long_enable  <= 1'b1;
              wait_cnt_reg      <= 16'd0;
            end else if (!power_trigger || (wait_cnt_reg >= short_to_reg)) begin
              // Losing power is a quiet drop; only a timeout is an abort.
              if (power_trigger) abort_count <= abort_count_sat;
              state_reg         <= S_FLUSH;
              sync_short_enable <= 1'b0;
              sync_long_enable  <= 1'b0;
              decode_enable     <= 1'b0;
              stage_reset       <= 1'b1;
              flush_cnt_reg     <= '0;
            end else begin
              wait_cnt_reg <= wait_cnt_reg + 16'd1;
            end
          end
        end

        S_LONG: begin
          if (!enable) begin
            state_reg         <= S_FLUSH;
            sync_short_enable <= 1'b0;
            sync_long_enable  <= 1'b0;
            decode_enable     <= 1'b0;
            stage_reset       <= 1'b1;
            flush_cnt_reg     <= '0;
          end else if (tick) begin
            if (long_detected) begin
              state_reg        <= S_DECODE;
              sync_long_enable <= 1'b0;
              decode_enable    <= 1'b1;
            end else if (wait_cnt_reg >= long_to_reg) begin
              abort_count       <= abort_count_sat;
              state_reg         <= S_FLUSH;
              sync_short_enable <= 1'b0;
              sync_long_enable  <= 1'b0;
              decode_enable     <= 1'b0;
              stage_reset       <= 1'b1;
              flush_cnt_reg     <= '0;
            end else begin
              wait_cnt_reg <= wait_cnt_reg + 16'd1;
            end
          end
        end

        S_DECODE: begin
          if (!enable || (tick && (pkt_fail || pkt_done))) begin
            // A failure outranks a simultaneous success.
            if (enable && pkt_fail)      abort_count <= abort_count_sat;
            else if (enable && pkt_done) pkt_count   <= pkt_count_sat;
            state_reg         <= S_FLUSH;
            sync_short_enable <= 1'b0;
            sync_long_enable  <= 1'b0;
            decode_enable     <= 1'b0;
            stage_reset       <= 1'b1;
            flush_cnt_reg     <= '0;
          end
        end

        S_FLUSH: begin
          // Counted in clocks, not sample ticks, and deaf to enable.
          if (flush_cnt_reg == FLUSH_LAST) begin
            state_reg   <= S_IDLE;
            stage_reset <= 1'b0;
          end else begin
            flush_cnt_reg <= flush_cnt_reg + 1'b1;
          end
        end

        default: begin
          state_reg         <= S_IDLE;
          sync_short_enable <= 1'b0;
          sync_long_enable  <= 1'b0;
          decode_enable     <= 1'b0;
          stage_reset       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rx_sequencer.sv
// Bench for rx_sequencer: each packet episode is planned up front, its
// outcome (state path, flush length, counters) is derived from the
// sequencing rules and queued; a monitor pops and compares whenever the
// DUT returns to IDLE.
module tb_rx_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        set_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;
  logic        sample_in_strobe;
  logic        power_trigger;
  logic        short_detected;
  logic        long_detected;
  logic        pkt_done;
  logic        pkt_fail;
  logic        sync_short_enable;
  logic        sync_long_enable;
  logic        decode_enable;
  logic        stage_reset;
  logic [2:0]  state;
  logic [15:0] pkt_count;
  logic [15:0] abort_count;

  rx_sequencer #(.SR_SHORT_TO(10), .SR_LONG_TO(11), .FLUSH_CYCLES(4)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .sample_in_strobe(sample_in_strobe), .power_trigger(power_trigger),
    .short_detected(short_detected), .long_detected(long_detected),
    .pkt_done(pkt_done), .pkt_fail(pkt_fail),
    .sync_short_enable(sync_short_enable), .sync_long_enable(sync_long_enable),
    .decode_enable(decode_enable), .stage_reset(stage_reset),
    .state(state), .pkt_count(pkt_count), .abort_count(abort_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    int seq;
    int flush_len;
    int pkt;
    int abort;
  } exp_t;

  exp_t exp_q[$];
  int   compared = 0;
  int   mismatched = 0;
  int   done_cnt = 0;
  int   ep_count = 0;
  bit   mon_on = 1'b0;
  int   exp_pkt = 0;
  int   exp_abort = 0;
  int   cur_short_to = 320;
  int   cur_long_to = 640;

  task automatic check(input string name, input int actual, input int required);
    compared++;
    if (actual != required) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, required);
    end
  endtask

  task automatic finish_sim();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  endtask

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  // Monitor: per-state output pattern every cycle, episode summary at return to IDLE.
  initial begin : monitor
    int prev;
    int seq;
    int sr;
    int exp_vec;
    exp_t e;
    prev = 0; seq = 0; sr = 0;
    forever begin
      @(negedge clock);
      if (mon_on) begin
        case (state)
          3'd0: exp_vec = 4'b0000;
          3'd1: exp_vec = 4'b1000;
          3'd2: exp_vec = 4'b0100;
          3'd3: exp_vec = 4'b0010;
          3'd4: exp_vec = 4'b0001;
          default: exp_vec = 4'b1111;
        endcase
        check("stage_outputs",
              int'({sync_short_enable, sync_long_enable, decode_enable, stage_reset}), exp_vec);
        if (prev == 0 && state != 3'd0) begin
          check("episode_expected", exp_q.size(), 1);
          seq = int'(state);
          sr = 0;
        end else if (int'(state) != prev && state != 3'd0) begin
          seq = seq * 8 + int'(state);
        end
        if (stage_reset) sr++;
        if (prev != 0 && state == 3'd0) begin
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("state_path", seq, e.seq);
            check("flush_len", sr, e.flush_len);
            check("pkt_count", int'(pkt_count), e.pkt);
            check("abort_count", int'(abort_count), e.abort);
          end
          done_cnt++;
        end
      end
      prev = int'(state);
    end
  end

  initial begin : watchdog
    #500000;
    mismatched++;
    $display("FAIL watchdog: simulation time limit reached");
    finish_sim();
  end

  // ---------------- stimulus helpers ----------------
  task automatic noise();
    short_detected = rb();
    long_detected  = rb();
    pkt_done       = rb();
    pkt_fail       = rb();
    power_trigger  = rb();
    set_stb        = rb();
    set_addr       = 8'($urandom_range(12, 255));
    set_data       = $urandom;
  endtask

  task automatic idle_cycle();
    noise();
    enable = 1'b1;
    sample_in_strobe = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic tick(input bit pwr, input bit sd, input bit ld, input bit dn, input bit fl);
    int n;
    n = $urandom_range(0, 2);
    repeat (n) idle_cycle();
    enable = 1'b1; set_stb = 1'b0; sample_in_strobe = 1'b1;
    power_trigger = pwr; short_detected = sd; long_detected = ld;
    pkt_done = dn; pkt_fail = fl;
    @(posedge clock); #1;
    sample_in_strobe = 1'b0;
  endtask

  task automatic force_tick(input bit pwr);
    enable = 1'b1; set_stb = 1'b0; sample_in_strobe = 1'b1;
    power_trigger = pwr; short_detected = 1'b0; long_detected = 1'b0;
    pkt_done = 1'b0; pkt_fail = 1'b0;
    @(posedge clock); #1;
    sample_in_strobe = 1'b0;
  endtask

  task automatic write_reg(input logic [7:0] a, input int v);
    enable = 1'b1; sample_in_strobe = 1'b0;
    set_stb = 1'b1; set_addr = a; set_data = {16'($urandom), 16'(v)};
    @(posedge clock); #1;
    set_stb = 1'b0;
  endtask

  // One packet attempt. Tick indices count sample ticks inside each phase from 0.
  // ds/dl: detection tick, dp: first tick with power low, dd: idle decode ticks,
  // outcome 0=done 1=fail 2=both, de: LONG tick before which enable drops,
  // w: SHORT tick after which short_to is rewritten to s_new (-1 = none).
  task automatic run_episode(input int s_to, input int l_to, input int ds, input int dp,
                             input int dl, input int dd, input int outcome,
                             input int de, input int w, input int s_new);
    int k, s_eff, short_end, short_ticks, long_end, long_ticks, seq, ab, pk, bound;
    exp_t e;
    if (s_to != cur_short_to) begin write_reg(8'd10, s_to); cur_short_to = s_to; end
    if (l_to != cur_long_to)  begin write_reg(8'd11, l_to); cur_long_to = l_to; end

    // SHORT: detection beats power loss beats timeout.
    k = 0; short_end = 2;
    forever begin
      s_eff = (w >= 0 && k > w) ? s_new : s_to;
      if (k == ds) begin short_end = 0; break; end
      if (k >= dp) begin short_end = 1; break; end
      if (k >= s_eff) begin short_end = 2; break; end
      k++;
    end
    short_ticks = k + 1;

    long_end = -1; long_ticks = 0;
    if (short_end == 0) begin
      k = 0;
      forever begin
        if (de >= 0 && k == de) begin long_end = 1; long_ticks = k; break; end
        if (k == dl) begin long_end = 0; long_ticks = k + 1; break; end
        if (k >= l_to) begin long_end = 2; long_ticks = k + 1; break; end
        k++;
      end
    end

    seq = 1; ab = 0; pk = 0;
    if (short_end == 0) begin
      seq = seq * 8 + 2;
      if (long_end == 0) begin
        seq = seq * 8 + 3;
        if (outcome == 0) pk = 1; else ab = 1;
      end else if (long_end == 2) begin
        ab = 1;
      end
    end else if (short_end == 2) begin
      ab = 1;
    end
    seq = seq * 8 + 4;
    exp_pkt   = sat16(exp_pkt + pk);
    exp_abort = sat16(exp_abort + ab);
    e.seq = seq; e.flush_len = 4; e.pkt = exp_pkt; e.abort = exp_abort;
    exp_q.push_back(e);
    ep_count++;

    // Drive: trigger edge, then each phase as planned.
    tick(1'b1, rb(), rb(), rb(), rb());
    for (int i = 0; i < short_ticks; i++) begin
      tick(i < dp, i == ds, rb(), rb(), rb());
      if (i == w) begin write_reg(8'd10, s_new); cur_short_to = s_new; end
    end
    for (int i = 0; i < long_ticks; i++) tick(rb(), rb(), i == dl, rb(), rb());
    if (long_end == 1) begin
      enable = 1'b0; sample_in_strobe = rb(); power_trigger = 1'b1; set_stb = 1'b0;
      @(posedge clock); #1;
      enable = 1'b1; sample_in_strobe = 1'b0;
    end
    if (long_end == 0) begin
      for (int i = 0; i < dd; i++) tick(rb(), rb(), rb(), 1'b0, 1'b0);
      tick(rb(), rb(), rb(), outcome != 1, outcome != 0);
    end

    // Aftermath: power held high must not re-arm without a new edge.
    if (short_end != 1) begin
      repeat (8) force_tick(1'b1);
      repeat (3) force_tick(1'b0);
    end else begin
      repeat (8) force_tick(1'b0);
    end

    bound = 0;
    while (done_cnt < ep_count && bound < 100) begin
      @(posedge clock); #1;
      bound++;
    end
    if (done_cnt < ep_count) begin
      check("episode_complete", done_cnt, ep_count);
      finish_sim();
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin : driver
    reset = 1'b1; enable = 1'b1; set_stb = 1'b0; set_addr = 8'd0; set_data = 32'd0;
    sample_in_strobe = 1'b0; power_trigger = 1'b0; short_detected = 1'b0;
    long_detected = 1'b0; pkt_done = 1'b0; pkt_fail = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst_state", int'(state), 0);
    check("rst_short_en", int'(sync_short_enable), 0);
    check("rst_long_en", int'(sync_long_enable), 0);
    check("rst_decode_en", int'(decode_enable), 0);
    check("rst_stage_reset", int'(stage_reset), 0);
    check("rst_pkt_count", int'(pkt_count), 0);
    check("rst_abort_count", int'(abort_count), 0);
    @(posedge clock); #1;
    mon_on = 1'b1;

    // Happy path with reset-value timeouts.
    run_episode(320, 640, 50, 999, 100, 0, 0, -1, -1, 0);
    // Short timeout of 5.
    run_episode(5, 640, 999, 999, 0, 0, 0, -1, -1, 0);
    // Power drop in SHORT.
    run_episode(320, 640, 999, 3, 0, 0, 0, -1, -1, 0);
    // done and fail together.
    run_episode(320, 640, 2, 999, 4, 1, 2, -1, -1, 0);
    // enable low in LONG.
    run_episode(320, 640, 1, 999, 50, 0, 0, 5, -1, 0);
    // Timeout lowered below the running counter mid-SHORT.
    run_episode(320, 640, 999, 999, 0, 0, 0, -1, 6, 3);
    // Zero timeouts: abort on first tick, detection still wins on tick 0.
    run_episode(0, 640, 999, 999, 0, 0, 0, -1, -1, 0);
    run_episode(0, 0, 0, 999, 999, 2, 1, -1, -1, 0);
    run_episode(3, 4, 3, 999, 4, 0, 0, -1, -1, 0);

    for (int n = 0; n < 40; n++) begin
      run_episode($urandom_range(0, 12), $urandom_range(0, 12),
                  ($urandom_range(0, 3) == 0) ? 999 : $urandom_range(0, 15),
                  ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : 999,
                  $urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 2),
                  ($urandom_range(0, 4) == 0) ? $urandom_range(0, 6) : -1,
                  ($urandom_range(0, 4) == 0) ? $urandom_range(0, 5) : -1,
                  $urandom_range(0, 10));
    end

    // Saturation: jump abort_count close to the top, then keep timing out.
    force dut.abort_count = 16'hFFFD;
    @(posedge clock); #1;
    release dut.abort_count;
    exp_abort = 65533;
    repeat (4) run_episode(0, 640, 999, 999, 0, 0, 0, -1, -1, 0);

    // Reset in the middle of FLUSH.
    mon_on = 1'b0;
    write_reg(8'd11, 640); cur_long_to = 640;
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    enable = 1'b0; power_trigger = 1'b1;
    @(posedge clock); #1;
    enable = 1'b1;
    @(negedge clock);
    check("edrop_state", int'(state), 4);
    check("edrop_stage_reset", int'(stage_reset), 1);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("flush_rst_state", int'(state), 0);
    check("flush_rst_stage_reset", int'(stage_reset), 0);
    check("flush_rst_enables",
          int'({sync_short_enable, sync_long_enable, decode_enable}), 0);
    check("flush_rst_pkt_count", int'(pkt_count), 0);
    check("flush_rst_abort_count", int'(abort_count), 0);

    finish_sim();
  end

endmodule
